// File: rtl/hex7seg_scan.sv
// Multiplexed hex 7-segment scanner with frame-latched inputs.
// Define HEX7SEG_LZB_EN to enable leading-zero blanking.
module hex7seg_scan #(
   parameter int NDIGITS        = 4,
   parameter int REFRESH_CYCLES = 100000
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic [4*NDIGITS-1:0]   x,
   input  logic [NDIGITS-1:0]     dp_in,
   input  logic [NDIGITS-1:0]     blank,
   output logic [6:0]             a_to_g,
   output logic                   dp,
   output logic [NDIGITS-1:0]     an
);

   localparam int PW = $clog2(REFRESH_CYCLES);
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   logic [PW-1:0]          presc_q, presc_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [4*NDIGITS-1:0]   frame_x_q, frame_x_d;
   logic [NDIGITS-1:0]     frame_dp_q, frame_dp_d;
   logic [NDIGITS-1:0]     frame_blank_q, frame_blank_d;
   logic                   valid_q, valid_d;
   logic [6:0]             a_to_g_q, a_to_g_d;
   logic                   dp_q, dp_d;
   logic [NDIGITS-1:0]     an_q, an_d;

   logic                   capture;
   logic [3:0]             cur_nib;
   logic                   cur_dp;
   logic                   cur_blank;
   logic [NDIGITS-1:0]     sel;

   function automatic logic [6:0] hex_dec(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

`ifdef HEX7SEG_LZB_EN
   logic [NDIGITS-1:0]     lz;
   logic                   lz_run;
   logic                   cur_lz;

   // lz[k] set when digit k and every more-significant digit are zero
   always_comb begin
      lz     = '0;
      lz_run = 1'b1;
      for (int k = NDIGITS - 1; k >= 1; k--) begin
         lz_run = lz_run & (frame_x_q[4*k +: 4] == 4'h0);
         lz[k]  = lz_run;
      end
   end
`endif

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == PW'(REFRESH_CYCLES - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      capture       = (presc_q == '0) && (idx_q == '0);
      frame_x_d     = capture ? x     : frame_x_q;
      frame_dp_d    = capture ? dp_in : frame_dp_q;
      frame_blank_d = capture ? blank : frame_blank_q;
      valid_d       = valid_q | capture;
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      sel       = '0;
`ifdef HEX7SEG_LZB_EN
      cur_lz    = 1'b0;
`endif
      for (int k = 0; k < NDIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_nib   = frame_x_q[4*k +: 4];
            cur_dp    = frame_dp_q[k];
            cur_blank = frame_blank_q[k];
            sel[k]    = 1'b1;
`ifdef HEX7SEG_LZB_EN
            cur_lz    = lz[k];
`endif
         end
      end

      an_d     = '1;
      a_to_g_d = 7'b1111111;
      dp_d     = 1'b1;
      if (valid_q && !cur_blank) begin
         an_d     = ~sel;
         a_to_g_d = hex_dec(cur_nib);
         dp_d     = ~cur_dp;
`ifdef HEX7SEG_LZB_EN
         if (cur_lz) a_to_g_d = 7'b1111111;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         presc_q       <= '0;
         idx_q         <= '0;
         frame_x_q     <= '0;
         frame_dp_q    <= '0;
         frame_blank_q <= '0;
         valid_q       <= 1'b0;
         a_to_g_q      <= 7'b1111111;
         dp_q          <= 1'b1;
         an_q          <= '1;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         frame_x_q     <= frame_x_d;
         frame_dp_q    <= frame_dp_d;
         frame_blank_q <= frame_blank_d;
         valid_q       <= valid_d;
         a_to_g_q      <= a_to_g_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
      end
   end

   assign a_to_g = a_to_g_q;
   assign dp     = dp_q;
   assign an     = an_q;

endmodule

// File: tb/tb_hex7seg_scan.sv
// Directed bench for hex7seg_scan at NDIGITS=4, REFRESH_CYCLES=4.
// Edge count e restarts at 0 on the last reset edge.
module tb_hex7seg_scan;

   localparam int ND = 4;
   localparam int RC = 4;

   logic          clk = 1'b0;
   logic          clr;
   logic [15:0]   x;
   logic [3:0]    dp_in;
   logic [3:0]    blank;
   logic [6:0]    a_to_g;
   logic          dp;
   logic [3:0]    an;

   int total = 0;
   int bad   = 0;
   int e     = 0;

`ifdef HEX7SEG_LZB_EN
   localparam logic [6:0] ZSEG = 7'b1111111;
`else
   localparam logic [6:0] ZSEG = 7'b0000001;
`endif

   always #5 clk = ~clk;

   hex7seg_scan #(.NDIGITS(ND), .REFRESH_CYCLES(RC)) dut (
      .clk    (clk),
      .clr    (clr),
      .x      (x),
      .dp_in  (dp_in),
      .blank  (blank),
      .a_to_g (a_to_g),
      .dp     (dp),
      .an     (an)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s e=%0d got=%h exp=%h", tag, e, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic to_edge(input int n);
      while (e < n) tick();
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] h);
      logic [6:0] t [16];
      t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      return t[h];
   endfunction

   function automatic logic [3:0] an_of(input int d);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << d);
   endfunction

   initial begin
      logic [15:0] fr;
      logic [3:0]  prev;
      int          d;
      int          run;
      bit          started;

      clr   = 1'b1;
      x     = 16'h12AF;
      dp_in = 4'b0000;
      blank = 4'b0000;
      repeat (3) tick();
      check("rst_an", an, 4'hF);
      check("rst_seg", a_to_g, 7'b1111111);
      check("rst_dp", dp, 1'b1);

      clr = 1'b0;
      e   = 0;
      fr  = 16'h12AF;
      tick();
      check("prevalid_an", an, 4'hF);
      for (int i = 2; i <= 17; i++) begin
         tick();
         d = ((e - 1) / RC) % ND;
         check("scan_an", an, an_of(d));
         check("scan_seg", a_to_g, seg_of(fr[4*d +: 4]));
         check("scan_dp", dp, 1'b1);
      end

      // change x mid-frame: old frame must persist
      to_edge(21);
      x = 16'h0000;
      for (int i = 22; i <= 32; i++) begin
         tick();
         d = ((e - 1) / RC) % ND;
         check("hold_an", an, an_of(d));
         check("hold_seg", a_to_g, seg_of(fr[4*d +: 4]));
      end
      to_edge(34);
      check("new_an0", an, 4'b1110);
      check("new_seg0", a_to_g, 7'b0000001);
      to_edge(37);
      check("new_an1", an, 4'b1101);
      check("new_seg1", a_to_g, ZSEG);
      to_edge(41);
      check("new_seg2", a_to_g, ZSEG);

      // blank and decimal point
      blank = 4'b0100;
      dp_in = 4'b0001;
      x     = 16'h12AF;
      to_edge(50);
      check("dp_an0", an, 4'b1110);
      check("dp_seg0", a_to_g, 7'b0111000);
      check("dp_dp0", dp, 1'b0);
      to_edge(54);
      check("dp_an1", an, 4'b1101);
      check("dp_dp1", dp, 1'b1);
      to_edge(58);
      check("blk_an2", an, 4'hF);
      check("blk_seg2", a_to_g, 7'b1111111);
      check("blk_dp2", dp, 1'b1);
      to_edge(62);
      check("blk_an3", an, 4'b0111);
      check("blk_seg3", a_to_g, 7'b1001111);

      // leading zeros
      blank = 4'b0000;
      dp_in = 4'b0000;
      x     = 16'h0050;
      to_edge(66);
      check("lz_seg0", a_to_g, 7'b0000001);
      to_edge(70);
      check("lz_seg1", a_to_g, 7'b0100100);
      to_edge(74);
      check("lz_an2", an, 4'b1011);
      check("lz_seg2", a_to_g, ZSEG);
      to_edge(78);
      check("lz_an3", an, 4'b0111);
      check("lz_seg3", a_to_g, ZSEG);

      // reset pulse while digit 3 active
      clr = 1'b1;
      tick();
      check("rp_an", an, 4'hF);
      check("rp_seg", a_to_g, 7'b1111111);
      check("rp_dp", dp, 1'b1);
      clr = 1'b0;
      e   = 0;
      tick();
      check("rp_an_e1", an, 4'hF);
      tick();
      check("rp_an_e2", an, 4'b1110);
      check("rp_seg_e2", a_to_g, 7'b0000001);

      // random data: one-hot anodes, fixed slot length
      prev    = an;
      run     = 1;
      started = 0;
      for (int i = 0; i < 1000; i++) begin
         x = 16'($urandom);
         tick();
         check("onehot", 32'($countones(~an) == 1), 32'd1);
         if (an == prev) begin
            run++;
         end else begin
            if (started) check("runlen", run, RC);
            started = 1;
            run     = 1;
            prev    = an;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
